imu_axis_sampler: RTL

- Periodic multi-channel sensor sampler; successor to the fixed three-axis accelerometer reader.
- On each sample tick, issues one burst register read through the I2C transaction master. It reassembles little-endian byte pairs into signed words and optionally averages 2^AVG_LOG2 bursts.
- Publishes a coherent, flattened sample vector with a one-cycle strobe.
- Sits between the I2C master and the attitude/roll-estimation logic.

---
 rtl/imu_axis_sampler_pkg.sv | 16 +
 rtl/imu_axis_sampler_if.sv | 25 ++
 rtl/imu_axis_sampler_tick.sv | 24 ++
 rtl/imu_axis_sampler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/imu_axis_sampler_pkg.sv
// Shared constants for the IMU sampler: BMI160 register map, channel width
// and the sampler FSM state encoding.
package imu_pkg;
  localparam int CH_W = 16;

  localparam logic [7:0] ACC_X_LSB   = 8'h12;
  localparam logic [7:0] GYR_X_LSB   = 8'h0C;
  localparam logic [6:0] BMI160_ADDR = 7'h68;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_RECV    = 3'd2;
  localparam state_t ST_ACCUM   = 3'd3;
  localparam state_t ST_PUBLISH = 3'd4;
endpackage

// File: rtl/imu_axis_sampler_if.sv
// Request/response link between the sampler (master) and the I2C
// transaction engine (slave).
interface imu_axis_sampler_if;
  // Request handshake: i2c_req stays high with stable dev/reg/len until the
  // cycle where i2c_req && i2c_req_ready, which is the single transfer.
  logic       i2c_req;
  logic       i2c_req_ready;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic [3:0] i2c_len;
  logic       i2c_rd_valid;
  logic [7:0] i2c_rd_data;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_len,
    input  i2c_req_ready, i2c_rd_valid, i2c_rd_data, i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_len,
    output i2c_req_ready, i2c_rd_valid, i2c_rd_data, i2c_done, i2c_nack
  );
endinterface

// File: rtl/imu_axis_sampler_tick.sv
// Free-running divider that emits a one-cycle tick every DIV cycles while
// enabled; held at zero when disabled.
module sample_tick_gen #(
  parameter int unsigned DIV = 500000
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n)              cnt <= '0;
    else if (!enable)        cnt <= '0;
    else if (cnt == LAST)    cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/imu_axis_sampler.sv
// Periodic burst reader: one I2C register burst per tick, little-endian word
// assembly, optional 2^AVG_LOG2 averaging, coherent strobed sample vector.
module imu_axis_sampler
  import imu_pkg::*;
#(
  parameter int         NUM_CH     = 3,
  parameter logic [6:0] DEV_ADDR   = BMI160_ADDR,
  parameter logic [7:0] BASE_REG   = ACC_X_LSB,
  parameter int         SAMPLE_DIV = 500000,
  parameter int         AVG_LOG2   = 0
) (
  input  logic                     clk_50mhz,
  input  logic                     rst_n,
  input  logic                     enable,
  imu_axis_sampler_if.master       i2c,
  output logic [NUM_CH*CH_W-1:0]   samples,
  output logic                     sample_valid,
  output logic                     busy,
  output logic [7:0]               err_count,
  output logic                     overrun,
  output state_t                   state_dbg
);
  localparam int NB     = 2 * NUM_CH;
  localparam int AW     = CH_W + AVG_LOG2;
  localparam int BURSTS = 1 << AVG_LOG2;
  localparam int IW     = $clog2(NB + 1);

  state_t                state, state_nxt;
  logic                  tick;
  logic [7:0]            byte_q   [NB];
  logic [IW-1:0]         byte_idx;
  logic [IW-1:0]         got_bytes;
  logic signed [CH_W-1:0] word    [NUM_CH];
  logic signed [AW-1:0]  acc_q    [NUM_CH];
  logic signed [AW-1:0]  acc_sum  [NUM_CH];
  logic [3:0]            burst_cnt;
  logic                  take_byte, burst_ok, last_burst;

  sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk_50mhz (clk_50mhz),
    .rst_n     (rst_n),
    .enable    (enable),
    .tick      (tick)
  );

  assign i2c.i2c_dev_addr = DEV_ADDR;
  assign i2c.i2c_reg_addr = BASE_REG;
  assign i2c.i2c_len      = 4'(NB);
  assign state_dbg        = state;

  // Surplus bytes are dropped and do not count toward the burst length.
  assign take_byte  = (state == ST_RECV) && i2c.i2c_rd_valid && (byte_idx < IW'(NB));
  assign got_bytes  = byte_idx + IW'(take_byte);
  assign burst_ok   = !i2c.i2c_nack && (got_bytes == IW'(NB));
  assign last_burst = (burst_cnt == 4'(BURSTS - 1));

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      word[k]    = {byte_q[2*k+1], byte_q[2*k]};
      acc_sum[k] = acc_q[k] + AW'(word[k]);
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (tick) state_nxt = ST_REQ;
      ST_REQ:     if (i2c.i2c_req_ready) state_nxt = ST_RECV;
      ST_RECV:    if (i2c.i2c_done) state_nxt = burst_ok ? ST_ACCUM : ST_IDLE;
      ST_ACCUM:   state_nxt = last_burst ? ST_PUBLISH : ST_IDLE;
      ST_PUBLISH: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    i2c.i2c_req  = (state == ST_REQ);
    busy         = (state == ST_REQ) || (state == ST_RECV) || (state == ST_ACCUM);
    sample_valid = (state == ST_PUBLISH);
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      byte_idx  <= '0;
      burst_cnt <= '0;
      err_count <= '0;
      overrun   <= 1'b0;
      samples   <= '0;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      for (int b = 0; b < NB; b++)     byte_q[b] <= '0;
    end else begin
      if (tick && (state != ST_IDLE)) overrun <= 1'b1;
      if (state == ST_REQ) byte_idx <= '0;
      if (take_byte) begin
        byte_q[byte_idx] <= i2c.i2c_rd_data;
        byte_idx         <= byte_idx + 1'b1;
      end
      if ((state == ST_RECV) && i2c.i2c_done && !burst_ok) begin
        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
        burst_cnt <= '0;
        for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      end
      // Samples load on the ACCUM->PUBLISH edge so they change with the strobe.
      if (state == ST_ACCUM) begin
        burst_cnt <= burst_cnt + 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          acc_q[k] <= acc_sum[k];
          if (last_burst) samples[k*CH_W +: CH_W] <= CH_W'(acc_sum[k] >>> AVG_LOG2);
        end
      end
      if (state == ST_PUBLISH) begin
        burst_cnt <= '0;
        for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      end
    end
  end
endmodule
